fx3_slave_fifo_responder: RTL

Synthesizable model of the Cypress FX3 GPIF II synchronous slave-FIFO device: the device end of the interface that the GLIP FX3 backend drives as master. It holds a host-to-logic buffer (read by the FPGA master) and a logic-to-host buffer (written by the FPGA master), and drives the four FIFO flags. It exposes both buffers to a host-side stream port. It is used for on-FPGA loopback of stress tests and as the device model in backend testbenches.

---
 rtl/fx3_slave_fifo_responder_if.sv | 41 ++++
 rtl/fx3_slave_fifo_responder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fx3_slave_fifo_responder_if.sv
// FX3 GPIF II slave-FIFO bus plus the host-side stream ports of the device model.
interface fx3_slave_fifo_responder_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] fx3_dq_i;
   logic [WIDTH-1:0] fx3_dq_o;
   logic             fx3_dq_oe;
   logic             fx3_slcs_n;
   logic             fx3_sloe_n;
   logic             fx3_slrd_n;
   logic             fx3_slwr_n;
   logic             fx3_pktend_n;
   logic [1:0]       fx3_a;
   logic             fx3_flaga_n;
   logic             fx3_flagb_n;
   logic             fx3_flagc_n;
   logic             fx3_flagd_n;
   logic [WIDTH-1:0] host_in_data;
   logic             host_in_valid;
   logic             host_in_ready;
   logic [WIDTH-1:0] host_out_data;
   logic             host_out_last;
   logic             host_out_valid;
   logic             host_out_ready;
   logic [15:0]      pkt_count;
   logic             proto_err;

   modport slave (
      input  fx3_dq_i, fx3_slcs_n, fx3_sloe_n, fx3_slrd_n, fx3_slwr_n, fx3_pktend_n, fx3_a,
      input  host_in_data, host_in_valid, host_out_ready,
      output fx3_dq_o, fx3_dq_oe, fx3_flaga_n, fx3_flagb_n, fx3_flagc_n, fx3_flagd_n,
      output host_in_ready, host_out_data, host_out_last, host_out_valid, pkt_count, proto_err
   );

   modport master (
      output fx3_dq_i, fx3_slcs_n, fx3_sloe_n, fx3_slrd_n, fx3_slwr_n, fx3_pktend_n, fx3_a,
      output host_in_data, host_in_valid, host_out_ready,
      input  fx3_dq_o, fx3_dq_oe, fx3_flaga_n, fx3_flagb_n, fx3_flagc_n, fx3_flagd_n,
      input  host_in_ready, host_out_data, host_out_last, host_out_valid, pkt_count, proto_err
   );
endinterface

// File: rtl/fx3_slave_fifo_responder.sv
// FX3 synchronous slave-FIFO device model: H2D buffer read by the FPGA master,
// D2H buffer written by it, both bridged to a host-side stream port.
module fx3_slave_fifo_responder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 512,
   parameter int unsigned WMARK = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   fx3_slave_fifo_responder_if.slave bus
);
   localparam int unsigned   AW        = $clog2(DEPTH);
   localparam int unsigned   PW        = AW + 1;
   localparam logic [PW-1:0] FULL_FILL = PW'(DEPTH);
   localparam logic [PW-1:0] HI_MARK   = PW'(DEPTH - WMARK);
   localparam logic [PW-1:0] LO_MARK   = PW'(WMARK);

   logic [PW-1:0]    d2h_wr_q, d2h_wr_d, d2h_rd_q, d2h_rd_d;
   logic [PW-1:0]    h2d_wr_q, h2d_wr_d, h2d_rd_q, h2d_rd_d;
   logic [PW-1:0]    d2h_fill, d2h_fill_d, h2d_fill, h2d_fill_d;
   logic [WIDTH:0]   d2h_mem [DEPTH];
   logic [WIDTH-1:0] h2d_mem [DEPTH];
   logic [WIDTH-1:0] rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d, dq_o_q, dq_o_d;
   logic [WIDTH:0]   head_q, head_d;
   logic             dq_oe_q, dq_oe_d;
   logic             flaga_n_q, flaga_n_d, flagb_n_q, flagb_n_d;
   logic             flagc_n_q, flagc_n_d, flagd_n_q, flagd_n_d;
   logic             host_in_ready_q, host_in_ready_d;
   logic             host_out_valid_q, host_out_valid_d;
   logic [15:0]      pkt_count_q, pkt_count_d;
   logic             proto_err_q, proto_err_d;
   logic             sel, wr_req, rd_req, pkt_req, bad_addr;
   logic             d2h_push, d2h_pop, h2d_push, h2d_pop;

   // Strobe decode, pointer/fill update and registered-output next values.
   always_comb begin
      sel      = !bus.fx3_slcs_n;
      wr_req   = sel && !bus.fx3_slwr_n && (bus.fx3_a == 2'b11);
      rd_req   = sel && !bus.fx3_slrd_n && (bus.fx3_a == 2'b00);
      pkt_req  = sel && !bus.fx3_pktend_n && (bus.fx3_a == 2'b11);
      bad_addr = sel && ((!bus.fx3_slwr_n && (bus.fx3_a != 2'b11)) ||
                         (!bus.fx3_slrd_n && (bus.fx3_a != 2'b00)));

      d2h_fill = d2h_wr_q - d2h_rd_q;
      h2d_fill = h2d_wr_q - h2d_rd_q;

      // Full/empty are judged on start-of-cycle fill: no bypass through a buffer.
      d2h_push = wr_req && (d2h_fill != FULL_FILL);
      d2h_pop  = host_out_valid_q && bus.host_out_ready;
      h2d_push = bus.host_in_valid && host_in_ready_q && (h2d_fill != FULL_FILL);
      h2d_pop  = rd_req && (h2d_fill != '0);

      d2h_wr_d   = d2h_wr_q + PW'(d2h_push);
      d2h_rd_d   = d2h_rd_q + PW'(d2h_pop);
      h2d_wr_d   = h2d_wr_q + PW'(h2d_push);
      h2d_rd_d   = h2d_rd_q + PW'(h2d_pop);
      d2h_fill_d = d2h_wr_d - d2h_rd_d;
      h2d_fill_d = h2d_wr_d - h2d_rd_d;

      // Head word for the next cycle; the word written this edge lands there when it becomes head.
      head_d = '0;
      if (d2h_fill_d != '0) begin
         if (d2h_push && (d2h_wr_q == d2h_rd_d)) head_d = {pkt_req, bus.fx3_dq_i};
         else                                     head_d = d2h_mem[d2h_rd_d[AW-1:0]];
      end

      rd_s1_d = h2d_pop ? h2d_mem[h2d_rd_q[AW-1:0]] : '0;
      rd_s2_d = rd_s1_q;
      dq_o_d  = rd_s2_q;
      dq_oe_d = sel && !bus.fx3_sloe_n && (bus.fx3_a == 2'b00);

      flaga_n_d        = (d2h_fill_d != FULL_FILL);
      flagb_n_d        = (d2h_fill_d < HI_MARK);
      flagc_n_d        = (h2d_fill_d != '0);
      flagd_n_d        = (h2d_fill_d > LO_MARK);
      host_in_ready_d  = (h2d_fill_d != FULL_FILL);
      host_out_valid_d = (d2h_fill_d != '0);
      pkt_count_d      = pkt_count_q + 16'(pkt_req);
      proto_err_d      = proto_err_q || bad_addr || (wr_req && !d2h_push) || (rd_req && !h2d_pop);
   end

   // Buffer storage carries no reset; emptiness is defined by the pointers.
   always_ff @(posedge clk) begin
      if (d2h_push) d2h_mem[d2h_wr_q[AW-1:0]] <= {pkt_req, bus.fx3_dq_i};
      if (h2d_push) h2d_mem[h2d_wr_q[AW-1:0]] <= bus.host_in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d2h_wr_q         <= '0;
         d2h_rd_q         <= '0;
         h2d_wr_q         <= '0;
         h2d_rd_q         <= '0;
         rd_s1_q          <= '0;
         rd_s2_q          <= '0;
         dq_o_q           <= '0;
         head_q           <= '0;
         dq_oe_q          <= 1'b0;
         flaga_n_q        <= 1'b1;
         flagb_n_q        <= 1'b1;
         flagc_n_q        <= 1'b0;
         flagd_n_q        <= 1'b0;
         host_in_ready_q  <= 1'b0;
         host_out_valid_q <= 1'b0;
         pkt_count_q      <= '0;
         proto_err_q      <= 1'b0;
      end else begin
         d2h_wr_q         <= d2h_wr_d;
         d2h_rd_q         <= d2h_rd_d;
         h2d_wr_q         <= h2d_wr_d;
         h2d_rd_q         <= h2d_rd_d;
         rd_s1_q          <= rd_s1_d;
         rd_s2_q          <= rd_s2_d;
         dq_o_q           <= dq_o_d;
         head_q           <= head_d;
         dq_oe_q          <= dq_oe_d;
         flaga_n_q        <= flaga_n_d;
         flagb_n_q        <= flagb_n_d;
         flagc_n_q        <= flagc_n_d;
         flagd_n_q        <= flagd_n_d;
         host_in_ready_q  <= host_in_ready_d;
         host_out_valid_q <= host_out_valid_d;
         pkt_count_q      <= pkt_count_d;
         proto_err_q      <= proto_err_d;
      end
   end

   assign bus.fx3_dq_o       = dq_o_q;
   assign bus.fx3_dq_oe      = dq_oe_q;
   assign bus.fx3_flaga_n    = flaga_n_q;
   assign bus.fx3_flagb_n    = flagb_n_q;
   assign bus.fx3_flagc_n    = flagc_n_q;
   assign bus.fx3_flagd_n    = flagd_n_q;
   assign bus.host_in_ready  = host_in_ready_q;
   assign bus.host_out_valid = host_out_valid_q;
   assign bus.host_out_data  = head_q[WIDTH-1:0];
   assign bus.host_out_last  = head_q[WIDTH];
   assign bus.pkt_count      = pkt_count_q;
   assign bus.proto_err      = proto_err_q;
endmodule
